mips_dmem_bridge: RTL

Data-side memory bridge directly downstream of the pipelined MIPS CPU's data port. Decodes each data access into either a word-addressed synchronous data RAM or a small MMIO space: a transmit byte FIFO with a valid/ready output, and a status register. Returns load data one cycle after the request, matching the CPU's M-stage read timing. Back-pressures the CPU through its global enable when a store targets a full FIFO.

---
 rtl/mips_dmem_bridge.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mips_dmem_bridge.sv
// mips_dmem_bridge: data-side bridge between the pipelined MIPS CPU data port,
// a word-addressed synchronous data RAM and a small MMIO space. The MMIO space
// holds a transmit byte FIFO (valid/ready drain) and a status register.
//
// Optional build macro: CYCLE_COUNTER_EN
//   defined   -> 32-bit free-running cycle counter readable/clearable at 0x8000_0008
//   undefined -> 0x8000_0008 is unmapped (reads 0, writes ignored)
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   en_in / cpu_en   global run enable in; CPU enable out (drops on a blocked TX store)
//   mem_*            CPU data port (byte address, big-endian lane enables, load request)
//   mem_read_data    load data, valid the cycle after mem_read_en
//   ram_*            synchronous data RAM port (one-cycle read latency)
//   tx_valid/tx_data/tx_ready  FIFO head and consumer handshake
module mips_dmem_bridge #(
  parameter int unsigned RAM_AW  = 12,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  output logic              cpu_en,
  input  logic [3:0]        mem_write_en,
  input  logic              mem_read_en,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_write_data,
  output logic [31:0]       mem_read_data,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  localparam logic [31:0] ADDR_TXDATA = 32'h8000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h8000_0004;
`ifdef CYCLE_COUNTER_EN
  localparam logic [31:0] ADDR_CYCLES = 32'h8000_0008;
`endif

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_MMIO = 2'd2
  } sel_e;

  // Region decode
  logic is_ram, is_tx, is_st, is_cyc, any_we;
  assign is_ram = (mem_addr[31:28] == 4'h0);
  assign is_tx  = (mem_addr == ADDR_TXDATA);
  assign is_st  = (mem_addr == ADDR_STATUS);
`ifdef CYCLE_COUNTER_EN
  assign is_cyc = (mem_addr == ADDR_CYCLES);
`else
  assign is_cyc = 1'b0;
`endif
  assign any_we = |mem_write_en;

  // FIFO state
  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               full, empty, stall, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(0));

  // Stall depends only on the registered count, never on tx_ready
  assign stall  = is_tx & any_we & full;
  assign cpu_en = en_in & ~stall;
  assign push   = cpu_en & is_tx & any_we;
  assign pop    = ~empty & tx_ready;

  assign tx_valid = ~empty;
  assign tx_data  = fifo_mem[rd_ptr_q];

  // RAM port
  assign ram_addr  = mem_addr[RAM_AW+1:2];
  assign ram_we    = mem_write_en & {4{is_ram & cpu_en}};
  assign ram_wdata = mem_write_data;

  // Read select and MMIO read register
  sel_e        sel_q, sel_d;
  logic [31:0] mmio_q, mmio_d;
  logic [31:0] status_val;

  assign status_val = {16'h0000, 8'(count_q), 6'b000000, full, empty};

  // Cycle counter
  logic [31:0] cyc_q, cyc_d;
`ifdef CYCLE_COUNTER_EN
  always_comb begin
    cyc_d = cyc_q + 32'd1;
    if (cpu_en & is_cyc & any_we) cyc_d = 32'h0;
  end
`else
  assign cyc_d = 32'h0;
`endif

  // Next-state for FIFO pointers, count and read select
  always_comb begin
    wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
    rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    sel_d    = SEL_NONE;
    mmio_d   = mmio_q;
    if (mem_read_en & cpu_en) begin
      if (is_ram) begin
        sel_d = SEL_RAM;
      end else if (is_tx) begin
        sel_d  = SEL_MMIO;
        mmio_d = 32'h0;
      end else if (is_st) begin
        sel_d  = SEL_MMIO;
        mmio_d = status_val;
      end else if (is_cyc) begin
        sel_d  = SEL_MMIO;
        mmio_d = cyc_q;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sel_q    <= SEL_NONE;
      mmio_q   <= 32'h0;
      cyc_q    <= 32'h0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sel_q    <= sel_d;
      mmio_q   <= mmio_d;
      cyc_q    <= cyc_d;
    end
  end

  // FIFO storage is not reset; a push coinciding with reset is discarded
  always_ff @(posedge clk) begin
    if (push & ~rst) fifo_mem[wr_ptr_q] <= mem_write_data[7:0];
  end

  // Load data return, one cycle after the qualified request
  always_comb begin
    mem_read_data = 32'h0;
    case (sel_q)
      SEL_RAM:  mem_read_data = ram_rdata;
      SEL_MMIO: mem_read_data = mmio_q;
      default:  mem_read_data = 32'h0;
    endcase
  end

endmodule
